// File: rtl/ajuste_relogio.sv
// Clock-setting controller: debounces mode/inc buttons and edits a shadow HH:MM in BCD,
// then strobes load so the time counters take the edited value with seconds cleared.
module ajuste_relogio #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [1:0] cur_h_msd,
  input  logic [3:0] cur_h_lsd,
  input  logic [2:0] cur_m_msd,
  input  logic [3:0] cur_m_lsd,
  output logic [1:0] set_h_msd,
  output logic [3:0] set_h_lsd,
  output logic [2:0] set_m_msd,
  output logic [3:0] set_m_lsd,
  output logic       load,
  output logic       editing,
  output logic [1:0] campo
);

  localparam int unsigned DbW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned ToW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_S - 1);

  typedef enum logic [1:0] {StRun, StEditH, StEditM, StCommit} state_e;

  // Index 0 is the mode button, index 1 the increment button.
  logic [1:0]     r_sync1, r_sync2, r_level;
  logic [DbW-1:0] r_db_cnt [2];
  logic [1:0]     w_press;
  logic           w_mode_press, w_inc_press;

  state_e         r_state, w_state_d;
  logic [ToW-1:0] r_to, w_to_d;
  logic [1:0]     r_h_msd, w_h_msd_d;
  logic [3:0]     r_h_lsd, w_h_lsd_d;
  logic [2:0]     r_m_msd, w_m_msd_d;
  logic [3:0]     r_m_lsd, w_m_lsd_d;
  logic           w_cur_h_ok, w_cur_m_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= {btn_inc, btn_mode};
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_level[i]) begin
          if (r_db_cnt[i] == DbLast) begin
            r_level[i]  <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Press fires in the cycle the new high level is about to be accepted.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_press[i] = r_sync2[i] & ~r_level[i] & (r_db_cnt[i] == DbLast);
    end
  end

  assign w_mode_press = w_press[0];
  assign w_inc_press  = w_press[1];

  // Out-of-range running time is captured as 00 rather than propagated into the shadow.
  assign w_cur_h_ok = (cur_h_lsd <= 4'd9) &&
                      ((cur_h_msd < 2'd2) || ((cur_h_msd == 2'd2) && (cur_h_lsd <= 4'd3)));
  assign w_cur_m_ok = (cur_m_msd <= 3'd5) && (cur_m_lsd <= 4'd9);

  always_comb begin
    w_state_d = r_state;
    w_to_d    = r_to;
    w_h_msd_d = r_h_msd;
    w_h_lsd_d = r_h_lsd;
    w_m_msd_d = r_m_msd;
    w_m_lsd_d = r_m_lsd;
    unique case (r_state)
      StRun: begin
        w_to_d = '0;
        if (w_mode_press) begin
          w_state_d = StEditH;
          w_h_msd_d = w_cur_h_ok ? cur_h_msd : 2'd0;
          w_h_lsd_d = w_cur_h_ok ? cur_h_lsd : 4'd0;
          w_m_msd_d = w_cur_m_ok ? cur_m_msd : 3'd0;
          w_m_lsd_d = w_cur_m_ok ? cur_m_lsd : 4'd0;
        end
      end
      StEditH, StEditM: begin
        if (w_mode_press) begin
          w_to_d    = '0;
          w_state_d = (r_state == StEditH) ? StEditM : StCommit;
        end else if (w_inc_press) begin
          w_to_d = '0;
          if (r_state == StEditH) begin
            if ((r_h_msd == 2'd2) && (r_h_lsd >= 4'd3)) begin
              w_h_msd_d = 2'd0;
              w_h_lsd_d = 4'd0;
            end else if (r_h_lsd >= 4'd9) begin
              w_h_msd_d = r_h_msd + 2'd1;
              w_h_lsd_d = 4'd0;
            end else begin
              w_h_lsd_d = r_h_lsd + 4'd1;
            end
          end else begin
            if (r_m_lsd >= 4'd9) begin
              w_m_lsd_d = 4'd0;
              w_m_msd_d = (r_m_msd >= 3'd5) ? 3'd0 : r_m_msd + 3'd1;
            end else begin
              w_m_lsd_d = r_m_lsd + 4'd1;
            end
          end
        end else if (enable1hz) begin
          if (r_to == ToLast) begin
            w_to_d    = '0;
            w_state_d = StRun;
          end else begin
            w_to_d = r_to + 1'b1;
          end
        end
      end
      StCommit: begin
        w_to_d    = '0;
        w_state_d = StRun;
      end
      default: begin
        w_to_d    = '0;
        w_state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StRun;
      r_to    <= '0;
      r_h_msd <= '0;
      r_h_lsd <= '0;
      r_m_msd <= '0;
      r_m_lsd <= '0;
    end else begin
      r_state <= w_state_d;
      r_to    <= w_to_d;
      r_h_msd <= w_h_msd_d;
      r_h_lsd <= w_h_lsd_d;
      r_m_msd <= w_m_msd_d;
      r_m_lsd <= w_m_lsd_d;
    end
  end

  assign set_h_msd = r_h_msd;
  assign set_h_lsd = r_h_lsd;
  assign set_m_msd = r_m_msd;
  assign set_m_lsd = r_m_lsd;
  assign load      = (r_state == StCommit);
  assign editing   = (r_state != StRun);
  assign campo     = (r_state == StEditH) ? 2'b01 :
                     (r_state == StEditM) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_ajuste_relogio.sv
// Scoreboard bench: a time-free model pushes each expected output tuple; a monitor pops one
// whenever the DUT's visible outputs change.
module tb_ajuste_relogio;

  localparam int unsigned DB   = 4;
  localparam int unsigned TO   = 3;
  localparam int unsigned HOLD = DB + 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [1:0] cur_h_msd = '0;
  logic [3:0] cur_h_lsd = '0;
  logic [2:0] cur_m_msd = '0;
  logic [3:0] cur_m_lsd = '0;
  logic [1:0] set_h_msd;
  logic [3:0] set_h_lsd;
  logic [2:0] set_m_msd;
  logic [3:0] set_m_lsd;
  logic       load, editing;
  logic [1:0] campo;

  ajuste_relogio #(.DB_CYCLES(DB), .TIMEOUT_S(TO)) dut (
    .clock(clock), .reset(reset), .enable1hz(enable1hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_h_msd(cur_h_msd), .cur_h_lsd(cur_h_lsd), .cur_m_msd(cur_m_msd), .cur_m_lsd(cur_m_lsd),
    .set_h_msd(set_h_msd), .set_h_lsd(set_h_lsd), .set_m_msd(set_m_msd), .set_m_lsd(set_m_lsd),
    .load(load), .editing(editing), .campo(campo)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass = 0;

  // Model: 0 run, 1 editing hours, 2 editing minutes.
  int m_state = 0;
  int m_h = 0, m_m = 0, m_to = 0;
  int c_h = 0, c_m = 0;
  logic [16:0] exp_q[$];
  logic [16:0] last_pushed = '0;
  bit mon_en = 1'b0;

  function automatic logic [16:0] mk(int l, int e, int c, int h, int m);
    return {1'(l), 1'(e), 2'(c), 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [16:0] dut_tup();
    return {load, editing, campo, set_h_msd, set_h_lsd, set_m_msd, set_m_lsd};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(logic [16:0] t);
    if (t != last_pushed) begin
      exp_q.push_back(t);
      last_pushed = t;
    end
  endtask

  task automatic model_mode();
    m_to = 0;
    case (m_state)
      0: begin m_h = c_h; m_m = c_m; m_state = 1; push(mk(0, 1, 1, m_h, m_m)); end
      1: begin m_state = 2; push(mk(0, 1, 2, m_h, m_m)); end
      default: begin
        push(mk(1, 1, 0, m_h, m_m));
        push(mk(0, 0, 0, m_h, m_m));
        m_state = 0;
      end
    endcase
  endtask

  task automatic model_inc();
    if (m_state == 1) begin m_h = (m_h + 1) % 24; m_to = 0; push(mk(0, 1, 1, m_h, m_m)); end
    else if (m_state == 2) begin m_m = (m_m + 1) % 60; m_to = 0; push(mk(0, 1, 2, m_h, m_m)); end
  endtask

  task automatic model_reset();
    m_state = 0; m_h = 0; m_m = 0; m_to = 0;
    push(mk(0, 0, 0, 0, 0));
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_cur(int h, int m);
    c_h = h; c_m = m;
    cur_h_msd = 2'(h / 10); cur_h_lsd = 4'(h % 10);
    cur_m_msd = 3'(m / 10); cur_m_lsd = 4'(m % 10);
  endtask

  task automatic press(bit pm, bit pi);
    if (pm) model_mode();
    else if (pi) model_inc();
    btn_mode = pm; btn_inc = pi;
    cyc(HOLD);
    btn_mode = 0; btn_inc = 0;
    cyc(HOLD);
  endtask

  task automatic bouncy_inc();
    model_inc();
    for (int k = 0; k < 10; k++) begin
      btn_inc = (k % 2 == 0);
      cyc(2);
    end
    btn_inc = 1;
    cyc(HOLD);
    btn_inc = 0;
    cyc(HOLD);
  endtask

  task automatic tick();
    if (m_state != 0) begin
      m_to++;
      if (m_to == TO) begin
        m_state = 0; m_to = 0;
        push(mk(0, 0, 0, m_h, m_m));
      end
    end
    enable1hz = 1;
    cyc(1);
    enable1hz = 0;
    cyc(2);
  endtask

  task automatic do_reset();
    model_reset();
    reset = 0;
    #1;
    chk("reset_outputs", 32'(dut_tup()), 32'(mk(0, 0, 0, 0, 0)));
    repeat (3) @(posedge clock);
    #3 reset = 1;
    cyc(1);
  endtask

  task automatic do_rand_cur();
    set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
  endtask

  initial begin : monitor
    logic [16:0] prev, cur, exp;
    prev = '0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        cur = dut_tup();
        if (cur != prev) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_change: got %0h expected no change", cur);
          end else begin
            exp = exp_q.pop_front();
            chk("output_tuple", 32'(cur), 32'(exp));
          end
        end
        if (cur[16]) chk("load_one_cycle", 32'(prev[16]), 32'd0);
        prev = cur;
      end
    end
  end

  initial begin : stim
    int n, op;
    #2 reset = 0;
    #1;
    chk("reset_load", 32'(load), 32'd0);
    chk("reset_editing", 32'(editing), 32'd0);
    chk("reset_campo", 32'(campo), 32'd0);
    chk("reset_set", 32'({set_h_msd, set_h_lsd, set_m_msd, set_m_lsd}), 32'd0);
    cyc(3);
    #2 reset = 1;
    cyc(1);
    mon_en = 1;

    // 12:34 -> 14:34 committed
    set_cur(12, 34);
    press(1, 0); press(0, 1); press(0, 1); press(1, 0); press(1, 0);
    // hour wrap from 22, minute wrap from 58
    set_cur(22, 58);
    press(1, 0); press(0, 1); press(0, 1); press(0, 1);
    press(1, 0); press(0, 1); press(0, 1); press(1, 0);
    // bouncing inc gives one increment
    set_cur(9, 9);
    press(1, 0); bouncy_inc(); press(1, 0); bouncy_inc(); press(1, 0);
    // timeout without load
    press(1, 0); tick(); tick(); tick();
    // ticks interrupted by a press restart the count
    press(1, 0); tick(); tick(); press(0, 1); tick(); tick(); tick();
    // simultaneous mode+inc in hours edit
    set_cur(5, 7);
    press(1, 0); press(1, 1); press(1, 0);
    // reset during minutes edit
    press(1, 0); press(1, 0); press(0, 1);
    do_reset();

    // Mode held through reset release: press after sync + DB cycles.
    set_cur(17, 45);
    btn_mode = 1;
    model_reset();
    reset = 0;
    #1;
    chk("reset_held_outputs", 32'(dut_tup()), 32'(mk(0, 0, 0, 0, 0)));
    repeat (3) @(posedge clock);
    #3 reset = 1;
    model_mode();
    n = 0;
    while (!editing && n < 40) begin
      @(posedge clock);
      n++;
      #1;
    end
    chk("press_latency_after_reset", 32'(n), 32'(2 + DB));
    btn_mode = 0;
    cyc(HOLD);
    press(1, 0); press(1, 0);

    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 9));
      if (m_state == 0) do_rand_cur();
      case (op)
        0, 1, 2: press(1, 0);
        3, 4, 5: press(0, 1);
        6:       bouncy_inc();
        7:       tick();
        8:       press(1, 1);
        default: if ($urandom_range(0, 3) == 0) do_reset(); else tick();
      endcase
    end

    cyc(20);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ajuste_relogio.md
AJUSTE_RELOGIO -- requirements
Module: ajuste_relogio

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000: consecutive stable cycles needed to accept a button level.
REQ-002 SHALL have parameter TIMEOUT_S, default 10: number of enable1hz pulses with no accepted press before an edit is abandoned.
REQ-003 SHALL have port clock, input, 1: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable1hz, input, 1: one-cycle 1 Hz tick, synchronous to clock.
REQ-006 SHALL have port btn_mode, input, 1: raw mode button, active-high, asynchronous to clock.
REQ-007 SHALL have port btn_inc, input, 1: raw increment button, active-high, asynchronous to clock.
REQ-008 SHALL have ports cur_h_msd, cur_h_lsd, cur_m_msd, cur_m_lsd, inputs, widths 2/4/3/4: running time in BCD.
REQ-009 SHALL have ports set_h_msd, set_h_lsd, set_m_msd, set_m_lsd, outputs, widths 2/4/3/4: shadow (edited) time in BCD.
REQ-010 SHALL have port load, output, 1: one-cycle strobe; the time counters load set_* hours/minutes and clear seconds to 00.
REQ-011 SHALL have port editing, output, 1: high in any edit state; the time counters hold while high.
REQ-012 SHALL have port campo, output, 2: field under edit; 00 none, 01 hours, 10 minutes, 11 unused.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer before debounce.
REQ-014 SHALL accept a new button level only after the synchronized level differs from the accepted level for DB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-015 SHALL generate a one-cycle press event on an accepted 0->1 transition; releases generate no event.
REQ-016 SHALL implement FSM states RUN, EDIT_H, EDIT_M, COMMIT.
REQ-017 RUN + mode press -> EDIT_H; shadow registers capture cur_* on the same edge.
REQ-018 EDIT_H + mode press -> EDIT_M; EDIT_M + mode press -> COMMIT; COMMIT -> RUN unconditionally after one cycle.
REQ-019 load SHALL be 1 only during the single COMMIT cycle; set_* SHALL hold the committed value in that cycle.
REQ-020 EDIT_H + inc press -> hours +1 in BCD, 23 wraps to 00 (09->10, 19->20).
REQ-021 EDIT_M + inc press -> minutes +1 in BCD, 59 wraps to 00; hours unchanged.
REQ-022 inc presses in RUN and COMMIT SHALL be ignored.
REQ-023 Mode and inc press in the same cycle: mode SHALL act, inc SHALL be discarded.
REQ-024 In EDIT_H/EDIT_M a timeout counter SHALL count enable1hz pulses, cleared on every accepted press; on reaching TIMEOUT_S the FSM SHALL go to RUN with no load pulse.
REQ-025 editing = 1 in EDIT_H, EDIT_M, COMMIT; campo = 01 in EDIT_H, 10 in EDIT_M, 00 otherwise.
REQ-026 set_* SHALL always output the shadow registers; shadow values SHALL never exceed 23:59.

Reset
REQ-027 While reset = 0: state RUN, load 0, editing 0, campo 00, shadow 00:00, timeout 0, debounce counters 0, accepted levels 0.
REQ-028 Reset asserted mid-edit SHALL abandon the edit immediately with no load pulse.
REQ-029 After reset release, a button held high SHALL produce one press event after the synchronizer plus DB_CYCLES.

Verification (DB_CYCLES=4, TIMEOUT_S=3)
REQ-030 cur=12:34, mode, inc x2, mode, mode -> set=14:34, load high exactly one cycle, then editing=0.
REQ-031 Edit hours from 22, inc x3 -> 23, 00, 01; edit minutes from 58, inc x2 -> 59, 00, hours unchanged.
REQ-032 btn_inc toggling every 2 cycles for 20 cycles, then stable high -> exactly one increment.
REQ-033 Enter EDIT_H, no presses, 3 enable1hz pulses -> state RUN, load never asserted.
REQ-034 Mode and inc presses accepted in the same cycle in EDIT_H -> EDIT_M entered, hours unchanged.
REQ-035 reset=0 during EDIT_M -> all outputs at reset values within the same cycle, no load.
